traffic_phase_scheduler: RTL and testbench

- Hardwired phase controller for the iCEBlink40 intersection demo.
- Latches car-sensor and pedestrian requests and shares the crossing between three requesters (NS traffic, EW traffic, pedestrians) in round-robin order.
- Sequences green, yellow, all-red and walk phases using a prescaled down-counter, and drives the four board LEDs plus a walk output.

---
 rtl/traffic_phase_scheduler_if.sv | 24 ++
 rtl/traffic_phase_scheduler.sv | 152 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// Request/lamp bundle for traffic_phase_scheduler: sensor and button requests in,
// lamp drives, acknowledge pulses and debug phase out.
interface traffic_phase_scheduler_if;
    logic       req_ns;
    logic       req_ew;
    logic       req_ped;
    logic       night;
    logic [3:0] leds;
    logic       walk;
    logic       ack_ns;
    logic       ack_ew;
    logic       ack_ped;
    logic [2:0] phase;

    modport master (
        output req_ns, req_ew, req_ped, night,
        input  leds, walk, ack_ns, ack_ew, ack_ped, phase
    );

    modport slave (
        input  req_ns, req_ew, req_ped, night,
        output leds, walk, ack_ns, ack_ew, ack_ped, phase
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Round-robin intersection phase controller (NS, EW, pedestrian) with prescaled dwell timer.
// Optional night flashing-yellow mode is enabled by defining TRAFFIC_NIGHT_FLASH_EN.
module traffic_phase_scheduler #(
    parameter int unsigned PRE_SCALE       = 2,
    parameter logic [7:0]  MIN_GREEN_TICKS = 8'd40,
    parameter logic [7:0]  YELLOW_TICKS    = 8'd10,
    parameter logic [7:0]  ALL_RED_TICKS   = 8'd4,
    parameter logic [7:0]  WALK_TICKS      = 8'd30
) (
    input logic                      clock,
    input logic                      reset_n,
    traffic_phase_scheduler_if.slave bus
);
    localparam int unsigned CW = 8 + PRE_SCALE;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        EW_GREEN  = 3'd2,
        EW_YELLOW = 3'd3,
        ALL_RED   = 3'd4,
        WALK      = 3'd5,
        FLASH     = 3'd6
    } state_t;

    typedef enum logic [1:0] {SRV_NS, SRV_EW, SRV_PED} served_t;

    state_t          state, state_n;
    served_t         last_served, served_n;
    logic [CW-1:0]   counter;
    logic            expire, reload;
    logic            pend_ns, pend_ew, pend_ped;
    logic            enter_ns, enter_ew, enter_ped;
    logic [3:0]      leds_q, leds_n;
    logic            walk_q, ack_ns_q, ack_ew_q, ack_ped_q;

    function automatic logic [CW-1:0] load_of(input state_t s);
        logic [7:0] t;
        case (s)
            NS_GREEN, EW_GREEN:   t = MIN_GREEN_TICKS;
            NS_YELLOW, EW_YELLOW: t = YELLOW_TICKS;
            WALK:                 t = WALK_TICKS;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH:                t = YELLOW_TICKS;
`endif
            default:              t = ALL_RED_TICKS;
        endcase
        return CW'(t) << PRE_SCALE;
    endfunction

    assign expire    = (counter == '0);
    assign enter_ns  = (state_n == NS_GREEN) && (state != NS_GREEN);
    assign enter_ew  = (state_n == EW_GREEN) && (state != EW_GREEN);
    assign enter_ped = (state_n == WALK)     && (state != WALK);

    always_comb begin
        state_n  = state;
        served_n = last_served;
        reload   = 1'b0;
        case (state)
            NS_GREEN:  if (expire && (pend_ew || pend_ped)) state_n = NS_YELLOW;
            EW_GREEN:  if (expire && (pend_ns || pend_ped)) state_n = EW_YELLOW;
            NS_YELLOW, EW_YELLOW, WALK: if (expire) state_n = ALL_RED;
            ALL_RED: if (expire) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
                if (bus.night) state_n = FLASH;
                else
`endif
                begin
                    // Search starts just after the last granted requester; with nothing
                    // pending the light rests in NS green without moving the pointer.
                    state_n = NS_GREEN;
                    case (last_served)
                        SRV_NS: begin
                            if (pend_ew)       begin state_n = EW_GREEN; served_n = SRV_EW;  end
                            else if (pend_ped) begin state_n = WALK;     served_n = SRV_PED; end
                            else if (pend_ns)  begin state_n = NS_GREEN; served_n = SRV_NS;  end
                        end
                        SRV_EW: begin
                            if (pend_ped)      begin state_n = WALK;     served_n = SRV_PED; end
                            else if (pend_ns)  begin state_n = NS_GREEN; served_n = SRV_NS;  end
                            else if (pend_ew)  begin state_n = EW_GREEN; served_n = SRV_EW;  end
                        end
                        default: begin
                            if (pend_ns)       begin state_n = NS_GREEN; served_n = SRV_NS;  end
                            else if (pend_ew)  begin state_n = EW_GREEN; served_n = SRV_EW;  end
                            else if (pend_ped) begin state_n = WALK;     served_n = SRV_PED; end
                        end
                    endcase
                end
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH: if (expire) begin
                if (bus.night) reload  = 1'b1;
                else           state_n = ALL_RED;
            end
`endif
            default: state_n = ALL_RED;
        endcase
    end

    always_comb begin
        leds_n = '0;
        case (state_n)
            NS_GREEN:  leds_n = 4'b1000;
            NS_YELLOW: leds_n = 4'b0100;
            EW_GREEN:  leds_n = 4'b0010;
            EW_YELLOW: leds_n = 4'b0001;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            // XOR with 0101 swaps between the NS and EW yellow lamps
            FLASH:     leds_n = (state != FLASH) ? 4'b0100 : (reload ? (leds_q ^ 4'b0101) : leds_q);
`endif
            default:   leds_n = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ALL_RED;
            last_served <= SRV_PED;
            counter     <= CW'(ALL_RED_TICKS) << PRE_SCALE;
            pend_ns     <= 1'b0;
            pend_ew     <= 1'b0;
            pend_ped    <= 1'b0;
            leds_q      <= '0;
            walk_q      <= 1'b0;
            ack_ns_q    <= 1'b0;
            ack_ew_q    <= 1'b0;
            ack_ped_q   <= 1'b0;
        end else begin
            state       <= state_n;
            last_served <= served_n;
            if ((state_n != state) || reload) counter <= load_of(state_n);
            else if (!expire)                 counter <= counter - CW'(1);
            pend_ns     <= enter_ns  ? 1'b0 : (pend_ns  | (bus.req_ns  && (state != NS_GREEN)));
            pend_ew     <= enter_ew  ? 1'b0 : (pend_ew  | (bus.req_ew  && (state != EW_GREEN)));
            pend_ped    <= enter_ped ? 1'b0 : (pend_ped | (bus.req_ped && (state != WALK)));
            ack_ns_q    <= enter_ns  & pend_ns;
            ack_ew_q    <= enter_ew  & pend_ew;
            ack_ped_q   <= enter_ped & pend_ped;
            leds_q      <= leds_n;
            walk_q      <= (state_n == WALK);
        end
    end

    assign bus.leds    = leds_q;
    assign bus.walk    = walk_q;
    assign bus.ack_ns  = ack_ns_q;
    assign bus.ack_ew  = ack_ew_q;
    assign bus.ack_ped = ack_ped_q;
    assign bus.phase   = state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: unscaled timing instance plus a PRE_SCALE=2 instance.
module tb_traffic_phase_scheduler;
    logic clk;
    logic rst_n;
    logic rst_ps_n;
    int   total;
    int   bad;

    traffic_phase_scheduler_if bus ();
    traffic_phase_scheduler_if bus_ps ();

    traffic_phase_scheduler #(
        .PRE_SCALE(0), .MIN_GREEN_TICKS(8'd4), .YELLOW_TICKS(8'd2),
        .ALL_RED_TICKS(8'd1), .WALK_TICKS(8'd3)
    ) u_dut (
        .clock(clk), .reset_n(rst_n), .bus(bus)
    );

    traffic_phase_scheduler #(
        .PRE_SCALE(2), .MIN_GREEN_TICKS(8'd4), .YELLOW_TICKS(8'd2),
        .ALL_RED_TICKS(8'd1), .WALK_TICKS(8'd3)
    ) u_dut_ps (
        .clock(clk), .reset_n(rst_ps_n), .bus(bus_ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] leds_of(input int ph);
        case (ph)
            0:       return 4'b1000;
            1:       return 4'b0100;
            2:       return 4'b0010;
            3:       return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_ns = 0; bus.req_ew = 0; bus.req_ped = 0; bus.night = 0;
        reset_dut();
        if (bus.phase !== 3'd4 || bus.leds !== 4'b0000 || bus.walk !== 1'b0) begin
            bad++; $display("FAIL reset_state phase=%0d leds=%b walk=%b exp phase=4 leds=0000 walk=0", bus.phase, bus.leds, bus.walk);
        end
        total++;
        if ({bus.ack_ns, bus.ack_ew, bus.ack_ped} !== 3'b000) begin
            bad++; $display("FAIL reset_acks got=%b exp=000", {bus.ack_ns, bus.ack_ew, bus.ack_ped});
        end
        total++;
        step();
        if (bus.phase !== 3'd4) begin bad++; $display("FAIL all_red_cycle2 phase=%0d exp=4", bus.phase); end
        total++;
        step();
        for (int i = 0; i < 50; i++) begin
            if (bus.phase !== 3'd0 || bus.leds !== 4'b1000) begin
                bad++; $display("FAIL rest_green cyc=%0d phase=%0d leds=%b exp phase=0 leds=1000", i, bus.phase, bus.leds);
            end
            total++;
            if ({bus.ack_ns, bus.ack_ew, bus.ack_ped} !== 3'b000) begin
                bad++; $display("FAIL rest_green_ack cyc=%0d got=%b exp=000", i, {bus.ack_ns, bus.ack_ew, bus.ack_ped});
            end
            total++;
            step();
        end
    endtask

    task automatic test_ew_request();
        int exp_ph [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 4, 4, 2, 2};
        reset_dut();
        step(); step();
        for (int i = 0; i < 12; i++) begin
            if (bus.phase !== 3'(exp_ph[i]) || bus.leds !== leds_of(exp_ph[i])) begin
                bad++; $display("FAIL ew_seq idx=%0d phase=%0d leds=%b exp phase=%0d leds=%b", i, bus.phase, bus.leds, exp_ph[i], leds_of(exp_ph[i]));
            end
            total++;
            if (bus.ack_ew !== (i == 10)) begin
                bad++; $display("FAIL ew_ack idx=%0d got=%b exp=%b", i, bus.ack_ew, (i == 10));
            end
            total++;
            if (i == 1) bus.req_ew = 1'b1;
            if (i == 2) bus.req_ew = 1'b0;
            step();
            if (i == 1) bus.req_ew = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int seg_ph [10]  = '{4, 0, 1, 4, 2, 3, 4, 5, 4, 0};
        int seg_len [10] = '{2, 5, 3, 2, 5, 3, 2, 4, 2, 1};
        logic [2:0] exp_ack;
        bus.req_ns = 1; bus.req_ew = 1; bus.req_ped = 1;
        reset_dut();
        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < seg_len[s]; k++) begin
                exp_ack = 3'b000;
                if (k == 0 && seg_ph[s] == 0) exp_ack = 3'b100;
                if (k == 0 && seg_ph[s] == 2) exp_ack = 3'b010;
                if (k == 0 && seg_ph[s] == 5) exp_ack = 3'b001;
                if (bus.phase !== 3'(seg_ph[s]) || bus.leds !== leds_of(seg_ph[s]) || bus.walk !== (seg_ph[s] == 5)) begin
                    bad++; $display("FAIL rr_seq seg=%0d k=%0d phase=%0d leds=%b walk=%b exp phase=%0d", s, k, bus.phase, bus.leds, bus.walk, seg_ph[s]);
                end
                total++;
                if ({bus.ack_ns, bus.ack_ew, bus.ack_ped} !== exp_ack) begin
                    bad++; $display("FAIL rr_ack seg=%0d k=%0d got=%b exp=%b", s, k, {bus.ack_ns, bus.ack_ew, bus.ack_ped}, exp_ack);
                end
                total++;
                step();
            end
        end
        bus.req_ns = 0; bus.req_ew = 0; bus.req_ped = 0;
    endtask

    task automatic test_reset_mid_walk();
        bus.req_ped = 1;
        reset_dut();
        step(); step();
        bus.req_ped = 0;
        if (bus.phase !== 3'd5 || bus.walk !== 1'b1 || bus.ack_ped !== 1'b1) begin
            bad++; $display("FAIL walk_entry phase=%0d walk=%b ack_ped=%b exp 5/1/1", bus.phase, bus.walk, bus.ack_ped);
        end
        total++;
        step();
        rst_n = 1'b0;
        #1;
        if (bus.walk !== 1'b0 || bus.leds !== 4'b0000 || bus.phase !== 3'd4) begin
            bad++; $display("FAIL async_reset walk=%b leds=%b phase=%0d exp 0/0000/4", bus.walk, bus.leds, bus.phase);
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        if (bus.phase !== 3'd4) begin bad++; $display("FAIL post_reset_red phase=%0d exp=4", bus.phase); end
        total++;
        step();
        if (bus.phase !== 3'd0 || bus.ack_ped !== 1'b0) begin
            bad++; $display("FAIL post_reset_green phase=%0d ack_ped=%b exp 0/0", bus.phase, bus.ack_ped);
        end
        total++;
    endtask

    task automatic test_prescale();
        int n;
        bus_ps.req_ns = 0; bus_ps.req_ew = 0; bus_ps.req_ped = 0; bus_ps.night = 0;
        rst_ps_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_ps_n = 1'b1;
        n = 0;
        while (bus_ps.phase == 3'd4 && n < 40) begin step(); n++; end
        if (n !== 5 || bus_ps.phase !== 3'd0) begin
            bad++; $display("FAIL ps_all_red dwell=%0d phase=%0d exp dwell=5 phase=0", n, bus_ps.phase);
        end
        total++;
        bus_ps.req_ew = 1;
        n = 0;
        while (bus_ps.phase == 3'd0 && n < 60) begin step(); n++; end
        if (n !== 17 || bus_ps.phase !== 3'd1) begin
            bad++; $display("FAIL ps_green dwell=%0d phase=%0d exp dwell=17 phase=1", n, bus_ps.phase);
        end
        total++;
        n = 0;
        while (bus_ps.phase == 3'd1 && n < 40) begin step(); n++; end
        if (n !== 9 || bus_ps.phase !== 3'd4) begin
            bad++; $display("FAIL ps_yellow dwell=%0d phase=%0d exp dwell=9 phase=4", n, bus_ps.phase);
        end
        total++;
        bus_ps.req_ew = 0;
    endtask

`ifdef TRAFFIC_NIGHT_FLASH_EN
    task automatic test_night();
        int  exp_ph [11] = '{4, 4, 6, 6, 6, 6, 6, 6, 4, 4, 2};
        logic [3:0] exp_leds [11] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100,
                                      4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
        bus.night = 1;
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            if (bus.phase !== 3'(exp_ph[i]) || bus.leds !== exp_leds[i]) begin
                bad++; $display("FAIL night_seq idx=%0d phase=%0d leds=%b exp phase=%0d leds=%b", i, bus.phase, bus.leds, exp_ph[i], exp_leds[i]);
            end
            total++;
            if (bus.ack_ew !== (i == 10)) begin
                bad++; $display("FAIL night_ack idx=%0d got=%b exp=%b", i, bus.ack_ew, (i == 10));
            end
            total++;
            if (i == 3) bus.req_ew = 1;
            if (i == 4) bus.req_ew = 0;
            if (i == 6) bus.night = 0;
            step();
        end
    endtask
`else
    task automatic test_night();
        bus.night = 1;
        reset_dut();
        step(); step();
        if (bus.phase !== 3'd0 || bus.leds !== 4'b1000) begin
            bad++; $display("FAIL night_ignored phase=%0d leds=%b exp phase=0 leds=1000", bus.phase, bus.leds);
        end
        total++;
        repeat (10) step();
        if (bus.phase !== 3'd0) begin bad++; $display("FAIL night_rest phase=%0d exp=0", bus.phase); end
        total++;
        bus.night = 0;
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        rst_ps_n = 1'b0;
        bus.req_ns = 0; bus.req_ew = 0; bus.req_ped = 0; bus.night = 0;
        bus_ps.req_ns = 0; bus_ps.req_ew = 0; bus_ps.req_ped = 0; bus_ps.night = 0;
        @(negedge clk);
        test_reset();
        test_ew_request();
        test_round_robin();
        test_reset_mid_walk();
        test_prescale();
        test_night();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
